// File: rtl/count_monitor_pkg.sv
// Shared types and helpers for the count monitor: FSM state encoding,
// wrap-tally width and the snapshot packing function.
package count_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        STALLED
    } mon_state_t;

    localparam int WRAP_CNT_W = 8;
    localparam int MAX_CNT_W  = 24;

    // Packs {wrap, cnt} with cnt occupying the low cnt_w bits; callers
    // truncate the result to WRAP_CNT_W + cnt_w.
    function automatic logic [WRAP_CNT_W+MAX_CNT_W-1:0] snap_pack(
        input logic [WRAP_CNT_W-1:0] wrap,
        input logic [MAX_CNT_W-1:0]  cnt,
        input int                    cnt_w
    );
        logic [WRAP_CNT_W+MAX_CNT_W-1:0] w;
        w = {{MAX_CNT_W{1'b0}}, wrap};
        return (w << cnt_w) | {{WRAP_CNT_W{1'b0}}, cnt};
    endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Observation and snapshot-drain signals of the count monitor. The master
// side drives the observed counter and consumes snapshots.
interface count_monitor_if
    import count_monitor_pkg::*;
#(
    parameter int CNT_W = 4
);
    logic [CNT_W-1:0]            count;
    logic                        enable;
    logic                        sample;
    logic                        out_ready;
    logic                        out_valid;
    logic [CNT_W+WRAP_CNT_W-1:0] out_data;
    logic                        wrap_pulse;
    logic [WRAP_CNT_W-1:0]       wrap_count;
    logic                        stall;
    logic                        overflow;

    modport master (
        output count, enable, sample, out_ready,
        input  out_valid, out_data, wrap_pulse, wrap_count, stall, overflow
    );

    modport slave (
        input  count, enable, sample, out_ready,
        output out_valid, out_data, wrap_pulse, wrap_count, stall, overflow
    );
endinterface

// File: rtl/count_monitor_snap_fifo.sv
// Snapshot FIFO with a registered head word and a sticky drop flag.
// A push into an empty FIFO is visible on the head right after that edge.
module snap_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [W-1:0]     head;
    logic             ovf;
    logic             full, empty, pop, wr_en, drop;

    assign full  = (occ == OCC_W'(DEPTH));
    assign empty = (occ == '0);
    assign pop   = !empty && ready;
    // A pop frees a slot in the same edge, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign valid    = !empty;
    assign dout     = head;
    assign overflow = ovf;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            head   <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;

            case ({wr_en, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            if (drop) ovf <= 1'b1;

            // The next head is either the following stored entry or the word
            // being written when the FIFO is (or becomes) empty.
            if (pop) begin
                if (occ > OCC_W'(1))
                    head <= mem[rd_ptr + 1'b1];
                else if (wr_en)
                    head <= din;
            end else if (empty && wr_en) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Observer for a free-running counter: wrap detection with a saturating
// tally, stall detection and on-demand snapshots into a FIFO.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 4,
    parameter int STALL_LIM = 8
) (
    input  logic           clk,
    input  logic           reset,
    count_monitor_if.slave bus
);
    localparam int                    SNAP_W   = CNT_W + WRAP_CNT_W;
    localparam int                    RUN_W    = $clog2(STALL_LIM + 1);
    localparam logic [RUN_W-1:0]      RUN_LIM  = RUN_W'(STALL_LIM);
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
    localparam logic [WRAP_CNT_W-1:0] WRAP_MAX = '1;

    mon_state_t            state;
    logic [CNT_W-1:0]      prev_count;
    logic [RUN_W-1:0]      stall_run;
    logic [RUN_W-1:0]      run_inc;
    logic                  wrap_pulse;
    logic                  stall;
    logic [WRAP_CNT_W-1:0] wrap_count;
    logic                  same;
    logic                  wrap_hit;
    logic                  push;
    logic [SNAP_W-1:0]     snap_din;

    assign same     = bus.enable && (bus.count == prev_count);
    assign wrap_hit = (prev_count == CNT_MAX) && (bus.count == '0);
    assign run_inc  = stall_run + 1'b1;

    // Snapshots carry the tally as it stood before this edge.
    assign push     = bus.sample && (state != IDLE);
    assign snap_din = SNAP_W'(snap_pack(wrap_count, MAX_CNT_W'(bus.count), CNT_W));

    assign bus.wrap_pulse = wrap_pulse;
    assign bus.wrap_count = wrap_count;
    assign bus.stall      = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev_count <= '0;
            stall_run  <= '0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            stall      <= 1'b0;
        end else begin
            prev_count <= bus.count;
            wrap_pulse <= 1'b0;

            if (state != IDLE && wrap_hit) begin
                wrap_pulse <= 1'b1;
                if (wrap_count != WRAP_MAX) wrap_count <= wrap_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    state <= TRACK;
                end
                TRACK: begin
                    if (same) begin
                        stall_run <= run_inc;
                        if (run_inc == RUN_LIM) begin
                            state <= STALLED;
                            stall <= 1'b1;
                        end
                    end else begin
                        stall_run <= '0;
                    end
                end
                STALLED: begin
                    if (!same) begin
                        stall_run <= '0;
                        stall     <= 1'b0;
                        state     <= TRACK;
                    end
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

    snap_fifo #(
        .W     (SNAP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (snap_din),
        .ready    (bus.out_ready),
        .valid    (bus.out_valid),
        .dout     (bus.out_data),
        .overflow (bus.overflow)
    );

endmodule

// File: doc/count_monitor.md
# count_monitor

Downstream observer for the 4-bit free-running counter. It watches the counter's `count` output and the `enable` that drives the counter, and does three things:
- detects wrap-around and keeps a saturating wrap tally;
- flags a stalled counter (enabled but not advancing);
- captures on-demand snapshots into a small FIFO drained over a valid/ready handshake.

It sits directly after the counter, feeding testbench checkers and the waveform-dump flow.

## Interface
Parameters:
- `CNT_W`, 4: width of the observed count.
- `DEPTH`, 4: snapshot FIFO entries; power of 2, ≥2.
- `STALL_LIM`, 8: consecutive enabled-but-unchanged cycles that declare a stall; ≥2.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high reset.
- `count`, in, CNT_W: counter output under observation.
- `enable`, in, 1: same enable that drives the counter.
- `sample`, in, 1: snapshot request, sampled each cycle.
- `out_ready`, in, 1: consumer ready.
- `out_valid`, out, 1: FIFO head valid.
- `out_data`, out, CNT_W+8: FIFO head, laid out as {wrap_count[7:0], count}.
- `wrap_pulse`, out, 1: one-cycle pulse per detected wrap.
- `wrap_count`, out, 8: saturating wrap tally.
- `stall`, out, 1: counter stalled.
- `overflow`, out, 1: sticky; a snapshot was dropped.

## Operation
The FSM has three states.
- **IDLE**: entered on reset. At the first edge with reset low, capture `prev_count <= count` and go to TRACK. No wrap or stall detection happens in IDLE.
- **TRACK**, every edge:
  - `prev_count <= count`.
  - Wrap condition is `prev_count == 2^CNT_W-1 && count == 0`. On a wrap, set `wrap_pulse` for one cycle and increment `wrap_count`, saturating at 255.
  - Stall counter `stall_run`:
    - if `enable` is high and `count == prev_count`: increment it;
    - otherwise: clear it.
  - When `stall_run` reaches STALL_LIM, go to STALLED.
- **STALLED**:
  - `stall` = 1.
  - Any change of `count`, or `enable` going low, clears `stall_run` and returns to TRACK.
  - Wrap detection stays active.

Snapshot FIFO:
- Push happens when `sample` is high in TRACK or STALLED. The entry is {wrap_count as registered before this edge, current `count`}.
- `sample` in IDLE is ignored.
- Pop happens when `out_valid && out_ready`.
- Push while full with no pop: the entry is dropped and `overflow` is set to 1. `overflow` stays set until reset.
- Push and pop in the same cycle while full: both take effect, occupancy unchanged, `overflow` not set.
- Ordering is strictly FIFO. `out_data` is the head and holds stable while `out_valid && !out_ready`.

## Timing
- Reset is synchronous. At the first edge with `reset` high, all outputs go to 0: `out_valid`, `out_data`, `wrap_pulse`, `wrap_count`, `stall`, `overflow`.
  - FIFO pointers and occupancy go to 0.
  - `stall_run` and `prev_count` go to 0.
  - FSM goes to IDLE.
- Reset mid-operation discards all FIFO entries; they are not drained.
- `wrap_pulse` is registered. It is high for the cycle after the edge at which `count` was observed at 0 following all-ones.
- Snapshot latency: `sample` high at edge N makes the entry visible on `out_valid`/`out_data` after edge N.
  - This holds even when the FIFO is empty; there is no combinational fall-through.
- Pop on an empty FIFO is impossible, because a pop requires `out_valid`.
- `stall` asserts at the edge where `stall_run` reaches STALL_LIM, i.e. STALL_LIM edges after the first unchanged observation. It deasserts one edge after the releasing condition.
- The wrap tally saturates: at 255, a further wrap still pulses `wrap_pulse` but the count stays at 255.

## Structure
- Package `count_monitor_pkg` holds:
  - `mon_state_t` enum {IDLE, TRACK, STALLED};
  - `WRAP_CNT_W = 8`;
  - helper function `snap_pack(wrap, cnt)`.
- Sub-module `snap_fifo`:
  - parameterised synchronous FIFO with width CNT_W+8 and depth DEPTH;
  - push/pop, full/empty and a registered head;
  - contains the overflow-sticky logic.
- The top level holds the FSM, wrap detection and stall counter.

## Test plan
All scenarios use defaults: CNT_W=4, DEPTH=4, STALL_LIM=8.
- **Wrap:** reset, then drive `count` 0→15→0 with `enable`=1 → one `wrap_pulse` cycle after 0 is observed; `wrap_count`=1; no pulse on the 0→1 step.
- **Single snapshot:** `wrap_count`=1, `sample` pulsed with `count`=5, `out_ready`=1 → `out_valid`=1 next cycle with `out_data`=12'h015, then 0 after the pop.
- **Overflow:** `out_ready`=0 and 5 samples with `count`=1..5 → `overflow`=1. Then drain with `out_ready`=1 → 12'h001, 002, 003, 004 in order, then `out_valid`=0.
- **Stall:** `enable`=1 with `count` held at 7 → `stall`=1 after 8 unchanged edges. `count`→8 → `stall`=0 next edge. Repeat with `enable` dropped mid-run → no stall.
- **Simultaneous push and pop on full FIFO:** `sample`=1 and `out_ready`=1 in the same cycle → occupancy stays 4, `overflow` stays 0, the new entry lands at the tail.
- **Reset mid-operation:** 3 entries queued, `stall`=1, `wrap_count`=9, then `reset` pulsed for 1 cycle → all outputs 0 at the next edge. The first post-reset cycle is IDLE: a `sample` there is ignored and a 15→0 step there gives no wrap.
